// File: rtl/serial_pkg.sv
// serial_pkg: frame layout and controller state encoding shared by the receive path
package serial_pkg;
  localparam int FRAME_W   = 10;
  localparam int DATA_W    = 7;
  localparam int START_BIT = 0;
  localparam int DATA_LSB  = 1;
  localparam int DATA_MSB  = 7;
  localparam int PAR_BIT   = 8;
  localparam int STOP_BIT  = 9;
  typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;
endpackage

// File: rtl/rx_char_fifo.sv
// rx_char_fifo: show-ahead character FIFO; a pop frees room for a same-cycle push when full
module rx_char_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign count   = cnt_q;
  assign rd_data = empty ? '0 : mem_q[rp_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Pointer, occupancy and storage updates; pointers wrap naturally at power-of-two depth
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wp_q] = wr_data;
    wp_d  = wp_q + AW'(do_push);
    rp_d  = rp_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/serial_rx_controller.sv
// serial_rx_controller: validates received frames, queues good characters, counts dropped frames
module serial_rx_controller
  import serial_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_enable,
  input  logic [FRAME_W-1:0]            rx_frame,
  input  logic                          rx_char_received,
  input  logic                          rd_req,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          framing_err,
  output logic                          overflow,
  output logic [CNT_W-1:0]              err_count,
  input  logic                          clr_err
);
  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               prev_q, perr_q, perr_d, ferr_q, ferr_d;
  logic               parity_q, parity_d, framing_q, framing_d, ovf_q, ovf_d;
  logic [CNT_W-1:0]   err_q, err_d, err_base;
  logic               new_frame, commit, bad, push, full, empty, drop, err_evt;
  assign new_frame = rx_char_received & ~prev_q;
  assign commit    = state_q == COMMIT;
  assign bad       = perr_q | ferr_q;
  assign push      = commit & ~bad;
  assign drop      = push & full & ~rd_req;
  assign err_evt   = commit & (bad | drop);
  rx_char_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (rd_req),
    .wr_data(frame_q[DATA_MSB:DATA_LSB]),
    .rd_data(rd_data),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );
  assign rd_valid    = ~empty;
  assign parity_err  = parity_q;
  assign framing_err = framing_q;
  assign overflow    = ovf_q;
  assign err_count   = err_q;
  // Frame sequencing: latch on a fresh strobe, check, then commit
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    case (state_q)
      IDLE: if (new_frame && rx_enable) begin
        frame_d = rx_frame;
        state_d = CHECK;
      end
      CHECK: begin
        perr_d  = ^frame_q[PAR_BIT:DATA_LSB];
        ferr_d  = frame_q[START_BIT] | ~frame_q[STOP_BIT];
        state_d = COMMIT;
      end
      default: state_d = IDLE;
    endcase
  end
  // Sticky flags and saturating drop counter; a coincident new error beats clr_err
  always_comb begin
    err_base  = clr_err ? '0 : err_q;
    err_d     = (err_evt && !(&err_base)) ? err_base + 1'b1 : err_base;
    parity_d  = (parity_q & ~clr_err) | (commit & perr_q);
    framing_d = (framing_q & ~clr_err) | (commit & ferr_q);
    ovf_d     = (ovf_q & ~clr_err) | drop;
  end
  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      prev_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      parity_q  <= 1'b0;
      framing_q <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      prev_q    <= rx_char_received;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      parity_q  <= parity_d;
      framing_q <= framing_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_serial_rx_controller.sv
// tb_serial_rx_controller: directed stimulus checked against a queue-based reference model
module tb_serial_rx_controller;
  localparam int DEPTH = 4;
  localparam int CMAX  = 255;
  logic       clk = 0, reset = 0, rx_enable = 0, rx_char_received = 0, rd_req = 0, clr_err = 0;
  logic [9:0] rx_frame = '0;
  logic [6:0] rd_data;
  logic       rd_valid, parity_err, framing_err, overflow;
  logic [2:0] fifo_count;
  logic [7:0] err_count;
  int total = 0, bad = 0;

  serial_rx_controller #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .rx_enable(rx_enable), .rx_frame(rx_frame),
    .rx_char_received(rx_char_received), .rd_req(rd_req), .rd_data(rd_data),
    .rd_valid(rd_valid), .fifo_count(fifo_count), .parity_err(parity_err),
    .framing_err(framing_err), .overflow(overflow), .err_count(err_count), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  logic [6:0] m_q[$];
  bit         m_perr, m_ferr, m_ovf, m_prev, m_pop, m_push, pe, fe;
  int         m_cnt, m_busy;
  logic [9:0] m_frame;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] mk(input logic [6:0] c);
    return {1'b1, ^c, c, 1'b0};
  endfunction

  // Reference model: a frame accepted on one edge is resolved two edges later
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_perr = 0; m_ferr = 0; m_ovf = 0; m_cnt = 0; m_busy = 0; m_prev = 0; m_frame = '0;
    end else begin
      m_pop  = rd_req && m_q.size() > 0;
      m_push = 0;
      if (clr_err) begin m_perr = 0; m_ferr = 0; m_ovf = 0; m_cnt = 0; end
      if (m_busy == 1) begin
        pe = ^m_frame[8:1];
        fe = m_frame[0] | !m_frame[9];
        if (pe || fe) begin
          m_perr |= pe; m_ferr |= fe;
          if (m_cnt < CMAX) m_cnt++;
        end else if (m_q.size() == DEPTH && !m_pop) begin
          m_ovf = 1;
          if (m_cnt < CMAX) m_cnt++;
        end else m_push = 1;
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_push) m_q.push_back(m_frame[7:1]);
      if (m_busy > 0) m_busy--;
      else if (rx_enable && rx_char_received && !m_prev) begin m_busy = 2; m_frame = rx_frame; end
      m_prev = rx_char_received;
    end
  end

  // Every-cycle comparison, away from the active edge
  always @(negedge clk) begin
    chk("rd_valid", 32'(rd_valid), 32'(m_q.size() > 0));
    chk("rd_data", 32'(rd_data), m_q.size() > 0 ? 32'(m_q[0]) : 32'h0);
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("parity_err", 32'(parity_err), 32'(m_perr));
    chk("framing_err", 32'(framing_err), 32'(m_ferr));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("err_count", 32'(err_count), 32'(m_cnt));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [9:0] f, input bit p = 0, input bit c = 0);
    rx_frame = f; rx_char_received = 1; tick();
    rx_char_received = 0; tick();
    rd_req = p; clr_err = c; tick();
    rd_req = 0; clr_err = 0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_err", 32'(err_count), 0);
    reset = 1; rx_enable = 1; tick();
    send(10'h296);
    chk("good_valid", 32'(rd_valid), 1);
    chk("good_data", 32'(rd_data), 32'h4B);
    chk("good_count", 32'(fifo_count), 1);
    chk("good_flags", {parity_err, framing_err, overflow}, 0);
    send(10'h31A);
    chk("second_head", 32'(rd_data), 32'h4B);
    chk("second_count", 32'(fifo_count), 2);
    rd_req = 1; tick(); rd_req = 0;
    chk("pop_data", 32'(rd_data), 32'h0D);
    chk("pop_count", 32'(fifo_count), 1);
    send(10'h396);
    chk("perr_flag", 32'(parity_err), 1);
    chk("perr_cnt", 32'(err_count), 1);
    chk("perr_nopush", 32'(fifo_count), 1);
    send(10'h096);
    chk("ferr_flag", 32'(framing_err), 1);
    chk("ferr_cnt", 32'(err_count), 2);
    clr_err = 1; tick(); clr_err = 0;
    chk("clr_flags", {parity_err, framing_err, err_count}, 0);
    rd_req = 1; repeat (2) tick(); rd_req = 0;
    chk("drain_empty", 32'(fifo_count), 0);
    rx_frame = 10'h296; rx_char_received = 1; repeat (20) tick(); rx_char_received = 0; tick();
    chk("level_once", 32'(fifo_count), 1);
    rx_enable = 0; send(10'h31A); tick();
    chk("gated", 32'(fifo_count), 1);
    rx_enable = 1;
    rd_req = 1; tick(); rd_req = 0;
    for (int i = 0; i < 5; i++) send(mk(7'(8'h11 + i)));
    chk("ovf_count", 32'(fifo_count), 4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_err", 32'(err_count), 1);
    chk("ovf_head", 32'(rd_data), 32'h11);
    clr_err = 1; tick(); clr_err = 0;
    send(mk(7'h22), 1);
    chk("full_pp_count", 32'(fifo_count), 4);
    chk("full_pp_ovf", 32'(overflow), 0);
    chk("full_pp_head", 32'(rd_data), 32'h12);
    rd_req = 1; repeat (4) tick(); rd_req = 0;
    send(mk(7'h33), 1);
    chk("empty_pp_count", 32'(fifo_count), 1);
    chk("empty_pp_data", 32'(rd_data), 32'h33);
    rd_req = 1; repeat (2) tick(); rd_req = 0;
    chk("underflow", 32'(fifo_count), 0);
    for (int i = 0; i < 260; i++) send(10'h396);
    chk("sat", 32'(err_count), CMAX);
    send(10'h396, 0, 1);
    chk("clr_vs_err_cnt", 32'(err_count), 1);
    chk("clr_vs_err_flag", 32'(parity_err), 1);
    rx_frame = mk(7'h44); rx_char_received = 1; tick();
    rx_char_received = 0; #1 reset = 0; #1;
    chk("async_rst", {rd_valid, fifo_count, parity_err, framing_err, overflow, err_count}, 0);
    tick(); reset = 1; tick();
    send(mk(7'h55));
    chk("post_rst_count", 32'(fifo_count), 1);
    chk("post_rst_data", 32'(rd_data), 32'h55);
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_rx_controller.md
Name: serial_rx_controller

Overview:
Sequences the serial receiver. It watches the receiver's 10-bit frame output and its charReceived strobe, then validates each frame for start, stop and even parity. Good 7-bit characters go into a small show-ahead FIFO for the processor-side reader; bad frames are dropped and counted. The block sits between the receiver and the processor bus, and is the only consumer of the receiver outputs.

Parameters:
FIFO_DEPTH, 4, number of character entries; power of two, 2..16
CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_enable  in  1  1 = accept new frames from the receiver
rx_frame  in  10  receiver data_out: [0]=start, [7:1]=data LSB-first, [8]=even parity, [9]=stop
rx_char_received  in  1  receiver charReceived; level, may stay high for several cycles
rd_req  in  1  pop the head entry this cycle
rd_data  out  7  head character (valid only while rd_valid=1)
rd_valid  out  1  FIFO not empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
parity_err  out  1  sticky: a frame failed the even-parity check
framing_err  out  1  sticky: start bit was not 0 or stop bit was not 1
overflow  out  1  sticky: a good frame was dropped because the FIFO was full
err_count  out  CNT_W  saturating count of dropped frames (all causes)
clr_err  in  1  synchronous clear of the sticky flags and err_count

Behaviour:
- Reset low, asynchronous: FSM=IDLE; FIFO empty; rd_valid=0; rd_data=0; fifo_count=0; all flags 0; err_count=0; edge-detect register=0.
- Edge detect: new frame = rx_char_received high now and low on the previous cycle. A level held high counts once.
- FSM states:
  - IDLE: on a new frame with rx_enable=1, latch rx_frame and go to CHECK. Edges seen with rx_enable=0 or outside IDLE are ignored.
  - CHECK: compute perr = ^frame[8:1] (must be 0 for even parity) and ferr = frame[0] | ~frame[9]. Go to COMMIT.
  - COMMIT: if perr or ferr, set the matching flags (both may set), do not push, err_count+1. Otherwise push frame[7:1]. Go to IDLE.
- Latency: edge sampled at edge N, latch at N, push at N+2, rd_valid and rd_data valid after edge N+2.
- Deasserting rx_enable during CHECK or COMMIT does not abort; the frame in flight completes.
- FIFO: show-ahead. rd_data is the head entry. rd_req with rd_valid=1 pops at the clock edge; rd_req with the FIFO empty is ignored and fifo_count does not underflow.
- Full, push, no pop: the new character is dropped, overflow=1, err_count+1.
- Full, push and pop in the same cycle: both happen, count unchanged, no overflow.
- Empty, push and pop in the same cycle: the pop is ignored and the push is accepted.
- Read and write pointers wrap modulo FIFO_DEPTH.
- err_count saturates at 2^CNT_W-1.
- clr_err clears the flags and err_count. If clr_err coincides with a COMMIT error, the new error wins: flag=1, err_count=1.

Decomposition:
- Package serial_pkg holds:
  - FRAME_W=10 and DATA_W=7
  - bit indices START_BIT=0, DATA_LSB=1, DATA_MSB=7, PAR_BIT=8, STOP_BIT=9
  - the FSM state encoding (IDLE, CHECK, COMMIT)
- One sub-module, rx_char_fifo: parameterised depth, show-ahead, with push, pop, full, empty and count. The controller contains only the FSM, the checks and the error bookkeeping.

Test Plan:
- Good frame: reset, rx_enable=1, rx_frame=10'h296, pulse rx_char_received -> after 2 edges rd_valid=1, rd_data=7'h4B, fifo_count=1, no flags set.
- Second good frame plus read: rx_frame=10'h31A -> rd_data stays 7'h4B and fifo_count=2. rd_req for 1 cycle -> rd_data=7'h0D, fifo_count=1.
- Error frames:
  - rx_frame=10'h396 (bad parity) -> parity_err=1, err_count=1, no push.
  - Then rx_frame=10'h096 (stop=0) -> framing_err=1, err_count=2.
  - clr_err -> all cleared.
- Level and enable gating:
  - rx_char_received held high for 20 cycles -> exactly one push.
  - With rx_enable=0, pulse rx_char_received -> no push, FSM stays IDLE.
- Overflow: 5 good frames with FIFO_DEPTH=4 and no reads -> fifo_count=4, overflow=1, err_count=1, and the head is still the first character.
- Same-cycle push and pop: with the FIFO full, a push and rd_req land on the same edge -> fifo_count stays 4, overflow stays 0.
- Reset mid-operation: assert reset during CHECK -> all outputs reset immediately; the next good frame after release is processed normally.
